temp_mode_ctrl: RTL and testbench

Synchronous controller for the four-mode temperature selector. It debounces the mode push-button and cycles the mode: ambient → hot → warm → cold → ambient. It drives the one-hot mode LEDs and sequences the heater and cooler actuators against a sampled temperature reading, with hysteresis, a minimum off-dwell between actuations, and a sensor-stale watchdog. It sits between the front-panel button and sensor interface and the heater/cooler drivers.

---
 rtl/temp_mode_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_temp_mode_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_mode_ctrl.sv
// Four-mode temperature selector: debounced mode button, one-hot mode LEDs, and a
// heater/cooler sequencer with hysteresis, minimum off-dwell and a stale-sensor watchdog.
module temp_mode_ctrl #(
   parameter int          DEBOUNCE_CYC = 16,
   parameter int          MIN_DWELL    = 256,
   parameter logic [7:0]  HYST         = 8'd2,
   parameter int          WDOG         = 1024,
   parameter logic [7:0]  SP_HOT       = 8'd60,
   parameter logic [7:0]  SP_WARM      = 8'd40,
   parameter logic [7:0]  SP_COLD      = 8'd10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic [7:0] temp,
   input  logic       temp_valid,
   output logic [1:0] mode,
   output logic [3:0] led,
   output logic       heat_en,
   output logic       cool_en,
   output logic       stale
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int DW_W = $clog2(MIN_DWELL + 1);
   localparam int WD_W = $clog2(WDOG + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(MIN_DWELL - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG);

   typedef enum logic [1:0] {IDLE, HEAT, COOL, DWELL} state_t;

   // ---------------- button path ----------------
   logic            sync1_reg, sync2_reg;
   logic            vld1_reg, vld2_reg;
   logic            block_reg;
   logic            deb_reg, deb_d_reg;
   logic            press_reg;
   logic [DB_W-1:0] db_cnt_reg;

   // block_reg suppresses the press of a button already held when reset is released;
   // it clears only once the synchronizer has seen a genuine low level after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         vld1_reg   <= 1'b0;
         vld2_reg   <= 1'b0;
         block_reg  <= 1'b1;
         deb_reg    <= 1'b0;
         deb_d_reg  <= 1'b0;
         press_reg  <= 1'b0;
         db_cnt_reg <= '0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
         vld1_reg  <= 1'b1;
         vld2_reg  <= vld1_reg;
         if (vld2_reg && !sync2_reg)
            block_reg <= 1'b0;
         if (sync2_reg != deb_reg) begin
            if (db_cnt_reg == DB_LAST) begin
               deb_reg    <= sync2_reg;
               db_cnt_reg <= '0;
            end else begin
               db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
         end else begin
            db_cnt_reg <= '0;
         end
         deb_d_reg <= deb_reg;
         press_reg <= deb_reg & ~deb_d_reg & ~block_reg;
      end
   end

   // ---------------- mode and setpoint ----------------
   logic [1:0] mode_reg, mode_next;
   logic [7:0] sp, lo, hi;
   logic [8:0] lo9, hi9;

   assign mode_next = press_reg ? mode_reg + 2'd1 : mode_reg;

   // Decisions use the post-press mode so a coincident press and reading agree.
   always_comb begin
      sp = 8'd0;
      case (mode_next)
         2'b01:   sp = SP_HOT;
         2'b10:   sp = SP_WARM;
         2'b11:   sp = SP_COLD;
         default: sp = 8'd0;
      endcase
      lo9 = {1'b0, sp} - {1'b0, HYST};
      hi9 = {1'b0, sp} + {1'b0, HYST};
      lo  = lo9[8] ? 8'd0 : lo9[7:0];
      hi  = hi9[8] ? 8'hFF : hi9[7:0];
   end

   // ---------------- watchdog ----------------
   logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
   logic            stale_reg, stale_next, stale_rise;

   always_comb begin
      wd_cnt_next = wd_cnt_reg;
      if (temp_valid)
         wd_cnt_next = '0;
      else if (wd_cnt_reg != WD_MAX)
         wd_cnt_next = wd_cnt_reg + WD_W'(1);
      stale_next = (wd_cnt_next == WD_MAX);
      stale_rise = stale_next & ~stale_reg;
   end

   // ---------------- actuator FSM ----------------
   state_t          state_reg, state_next;
   logic [DW_W-1:0] dwell_cnt_reg, dwell_cnt_next;
   logic            heat_reg, cool_reg;

   always_comb begin
      state_next     = state_reg;
      dwell_cnt_next = dwell_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (temp_valid && !stale_reg && mode_next != 2'b00) begin
               if (temp < lo)
                  state_next = HEAT;
               else if (temp > hi)
                  state_next = COOL;
            end
         end
         HEAT: begin
            if ((temp_valid && temp >= sp) || press_reg || stale_rise) begin
               state_next     = DWELL;
               dwell_cnt_next = '0;
            end
         end
         COOL: begin
            if ((temp_valid && temp <= sp) || press_reg || stale_rise) begin
               state_next     = DWELL;
               dwell_cnt_next = '0;
            end
         end
         DWELL: begin
            if (dwell_cnt_reg == DW_LAST) begin
               state_next     = IDLE;
               dwell_cnt_next = '0;
            end else begin
               dwell_cnt_next = dwell_cnt_reg + DW_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_reg      <= 2'b00;
         state_reg     <= IDLE;
         dwell_cnt_reg <= '0;
         wd_cnt_reg    <= '0;
         stale_reg     <= 1'b0;
         heat_reg      <= 1'b0;
         cool_reg      <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         state_reg     <= state_next;
         dwell_cnt_reg <= dwell_cnt_next;
         wd_cnt_reg    <= wd_cnt_next;
         stale_reg     <= stale_next;
         heat_reg      <= (state_next == HEAT);
         cool_reg      <= (state_next == COOL);
      end
   end

   // led[0..2] = hot/warm/cold (modes 1..3), led[3] = ambient (mode 0 wraps in 2 bits)
   for (genvar gi = 0; gi < 4; gi++) begin : g_led
      assign led[gi] = (mode_reg == 2'(gi + 1));
   end

   assign mode    = mode_reg;
   assign heat_en = heat_reg;
   assign cool_en = cool_reg;
   assign stale   = stale_reg;

endmodule

// File: tb/tb_temp_mode_ctrl.sv
// Directed plus randomized bench for temp_mode_ctrl, checked every cycle against a
// behavioural model of the mode/actuator/watchdog rules.
module tb_temp_mode_ctrl;
   localparam int D  = 4;
   localparam int MD = 8;
   localparam int WD = 32;

   logic       clk = 1'b0;
   logic       rst, btn, temp_valid;
   logic [7:0] temp;
   logic [1:0] mode;
   logic [3:0] led;
   logic       heat_en, cool_en, stale;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   int m_mode, m_heat, m_cool, m_stale, m_dwell, m_since;
   int press_q[$];

   temp_mode_ctrl #(
      .DEBOUNCE_CYC(D), .MIN_DWELL(MD), .HYST(8'd2), .WDOG(WD),
      .SP_HOT(8'd60), .SP_WARM(8'd40), .SP_COLD(8'd10)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .temp(temp), .temp_valid(temp_valid),
      .mode(mode), .led(led), .heat_en(heat_en), .cool_en(cool_en), .stale(stale)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic int sp_of(int m);
      case (m)
         1:       return 60;
         2:       return 40;
         3:       return 10;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
      end
   endtask

   // Model of one rising edge, applied with the inputs present at that edge.
   task automatic model_edge();
      bit press, nstale, srise;
      int nm, sp, lo, hi;
      if (!rst) begin
         m_mode = 0; m_heat = 0; m_cool = 0; m_stale = 0; m_dwell = 0; m_since = 0;
         press_q.delete();
         return;
      end
      press = 0;
      if (press_q.size() > 0 && press_q[0] == edge_no) begin
         press = 1;
         void'(press_q.pop_front());
      end
      nm      = press ? (m_mode + 1) % 4 : m_mode;
      m_since = temp_valid ? 0 : (m_since < WD ? m_since + 1 : WD);
      nstale  = (m_since >= WD);
      srise   = nstale && !m_stale;
      sp = sp_of(nm);
      lo = (sp - 2 < 0) ? 0 : sp - 2;
      hi = (sp + 2 > 255) ? 255 : sp + 2;
      if (m_heat != 0) begin
         if ((temp_valid && temp >= sp) || press || srise) begin m_heat = 0; m_dwell = MD; end
      end else if (m_cool != 0) begin
         if ((temp_valid && temp <= sp) || press || srise) begin m_cool = 0; m_dwell = MD; end
      end else if (m_dwell > 0) begin
         m_dwell--;
      end else if (temp_valid && m_stale == 0 && nm != 0) begin
         if (temp < lo) m_heat = 1;
         else if (temp > hi) m_cool = 1;
      end
      m_mode  = nm;
      m_stale = nstale;
   endtask

   task automatic tick();
      @(posedge clk);
      edge_no++;
      model_edge();
      #1;
      chk("mode", 8'(mode), 8'(m_mode));
      chk("led", 8'(led), 8'(1 << ((m_mode + 3) % 4)));
      chk("heat_en", 8'(heat_en), 8'(m_heat));
      chk("cool_en", 8'(cool_en), 8'(m_cool));
      chk("stale", 8'(stale), 8'(m_stale));
   endtask

   task automatic valid(input logic [7:0] t);
      temp = t;
      temp_valid = 1'b1;
      tick();
      temp_valid = 1'b0;
      $display("valid temp=%0d mode=%0d heat=%0d cool=%0d stale=%0d", t, mode, heat_en, cool_en, stale);
   endtask

   // Clean press: mode must move exactly D+3 edges after btn is first sampled high.
   task automatic press();
      btn = 1'b1;
      press_q.push_back(edge_no + 1 + D + 3);
      repeat (D + 4) tick();
      btn = 1'b0;
      repeat (10) tick();
      $display("press mode=%0d led=%b heat=%0d cool=%0d", mode, led, heat_en, cool_en);
   endtask

   initial begin
      int r;
      rst = 1'b0; btn = 1'b0; temp_valid = 1'b0; temp = 8'd0;
      repeat (3) tick();
      chk("rst_mode", 8'(mode), 8'd0);
      chk("rst_led", 8'(led), 8'b1000);
      chk("rst_heat", 8'(heat_en), 8'd0);
      rst = 1'b1;
      repeat (5) tick();

      // four clean presses
      press(); chk("p1_led", 8'(led), 8'b0001);
      press(); chk("p2_led", 8'(led), 8'b0010);
      press(); chk("p3_led", 8'(led), 8'b0100);
      press(); chk("p4_led", 8'(led), 8'b1000);

      // bounce then hold: one increment
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0);
         repeat (2) tick();
      end
      press();
      chk("bounce_mode", 8'(mode), 8'd1);
      // short pulse: no increment
      btn = 1'b1; repeat (3) tick();
      btn = 1'b0; repeat (10) tick();
      chk("pulse_mode", 8'(mode), 8'd1);

      // hot mode
      valid(8'd60);
      valid(8'd57); chk("hot_on", 8'(heat_en), 8'd1);
      valid(8'd59); chk("hot_hold", 8'(heat_en), 8'd1);
      valid(8'd60); chk("hot_off", 8'(heat_en), 8'd0);
      repeat (3) tick();
      valid(8'd50); chk("dwell_ignore", 8'(heat_en), 8'd0);
      repeat (4) tick();
      valid(8'd50); chk("after_dwell", 8'(heat_en), 8'd1);

      // to cold mode, then cool, then press to ambient
      press(); chk("press_drop", 8'(heat_en), 8'd0);
      press(); chk("cold_mode", 8'(mode), 8'd3);
      valid(8'd10); chk("stale_clr", 8'(stale), 8'd0);
      valid(8'd13); chk("cold_on", 8'(cool_en), 8'd1);
      press(); chk("amb_drop", 8'(cool_en), 8'd0);
      valid(8'd0);   chk("amb_lo", 8'(heat_en), 8'd0);
      valid(8'd255); chk("amb_hi", 8'(cool_en), 8'd0);

      // stale while heating
      press();
      valid(8'd60);
      valid(8'd50); chk("heat2_on", 8'(heat_en), 8'd1);
      repeat (WD) tick();
      chk("stale_up", 8'(stale), 8'd1);
      chk("stale_heat", 8'(heat_en), 8'd0);
      repeat (10) tick();
      valid(8'd30);
      chk("stale_noact", 8'(heat_en), 8'd0);
      chk("stale_gone", 8'(stale), 8'd0);

      // reset while cooling, button held through reset release
      valid(8'd70); chk("cool_on2", 8'(cool_en), 8'd1);
      rst = 1'b0; btn = 1'b1;
      tick();
      chk("mid_rst_cool", 8'(cool_en), 8'd0);
      chk("mid_rst_led", 8'(led), 8'b1000);
      tick();
      rst = 1'b1;
      repeat (20) tick();
      chk("held_nopress", 8'(mode), 8'd0);
      btn = 1'b0;
      repeat (10) tick();
      press(); chk("repress", 8'(mode), 8'd1);

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            temp_valid = 1'b0;
            press();
         end else if (r == 1) begin
            temp_valid = 1'b0;
            repeat (40) tick();
         end else begin
            repeat (10) begin
               if ($urandom_range(0, 1) == 0) begin
                  temp = 8'($urandom_range(0, 255));
               end else begin
                  int t;
                  t = sp_of(m_mode) + int'($urandom_range(0, 10)) - 5;
                  temp = 8'((t < 0) ? 0 : t);
               end
               temp_valid = ($urandom_range(0, 3) == 0);
               tick();
            end
            temp_valid = 1'b0;
         end
      end
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
